pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 id_uses_rt  input  1  the ID instruction reads rt (R-type, beq, bne, sw).
REQ-006 id_branch_taken, id_jump, id_halt  input  1 each  ID-stage branch-resolved-taken, jump, and halt opcode.
REQ-007 ex_memread  input  1; ex_rt, ex_rs  input  5 each  EX-stage load flag and register numbers.
REQ-008 mem_regwrite, wb_regwrite  input  1 each; mem_rd, wb_rd  input  5 each  writeback intent and destination registers.
REQ-009 step  input  1  single-step request; level input, synchronous to clk.
REQ-010 pc_write, ifid_write  output  1 each  PC and IF/ID enables.
REQ-011 ifid_flush, idex_flush  output  1 each  flush controls: IF/ID loads a nop; ID/EX loads a bubble.
REQ-012 fwd_a, fwd_b  output  2 each  EX operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-013 pipe_freeze  output  1  holds all four pipeline registers and the PC.
REQ-014 halted  output  1; stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-015 Load-use hazard (LU) SHALL be ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)), evaluated combinationally.
REQ-016 In RUN with LU: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0 in the same cycle; the stall SHALL last exactly 1 cycle per detected hazard.
REQ-017 In RUN without LU, (id_branch_taken | id_jump) SHALL assert ifid_flush=1 with pc_write=1 and ifid_write=1.
REQ-018 When LU and a branch/jump occur together, LU SHALL win and ifid_flush SHALL be 0.
REQ-019 fwd_a SHALL be 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs, else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs, else 00; fwd_b SHALL be the same with ex_rt; EX/MEM SHALL take priority.
REQ-020 FSM states SHALL be RUN, DRAIN, and HALTED.
REQ-021 RUN->DRAIN SHALL occur on id_halt & !LU; id_halt under LU SHALL be ignored until the stall clears.
REQ-022 On entry to DRAIN, a 2-bit drain counter SHALL load 3.
REQ-023 In DRAIN: pc_write=0, ifid_write=0, ifid_flush=1, and the counter SHALL decrement each cycle; at 0 the FSM SHALL move to HALTED, so halted rises on the 4th edge after the halt is seen.
REQ-024 In HALTED: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1, and halted=1; the FSM SHALL exit HALTED only on reset.
REQ-025 stall_cnt SHALL increment on every clk edge where a RUN-state LU stall occurs, and SHALL saturate at 16'hFFFF.
REQ-026 Branch, jump, and LU inputs SHALL be ignored in DRAIN and HALTED.

Reset
REQ-027 While rst_n=0: state=RUN, drain counter=0, stall_cnt=0, halted=0, pc_write=1, ifid_write=1, both flushes=0, fwd_a=fwd_b=00, pipe_freeze=0.
REQ-028 Reset asserted mid-DRAIN or mid-stall SHALL take effect immediately and asynchronously; the first post-reset cycle SHALL be RUN.

Configuration
REQ-029 Macro PIPE_STEP_EN, when defined, SHALL enable single-step: a rising edge of step (registered against its previous value) SHALL allow exactly one advance cycle; in all other cycles pipe_freeze=1, pc_write=0, ifid_write=0, both flushes=0, and the FSM, drain counter, and stall_cnt SHALL hold.
REQ-030 Without PIPE_STEP_EN, the step port SHALL be present but ignored, pipe_freeze SHALL be constant 0, and the block SHALL advance every cycle.

Verification
REQ-031 Load-use: ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle; stall_cnt 0->1.
REQ-032 Forward priority: ex_rs=9, mem_rd=9, wb_rd=9, both regwrite=1 -> fwd_a=10; mem_regwrite=0 -> fwd_a=01; mem_rd=wb_rd=0 -> fwd_a=00.
REQ-033 Simultaneous events: LU (ex_rt=id_rt=10, id_uses_rt=1) plus id_branch_taken=1 -> ifid_flush=0 and idex_flush=1; the next cycle without LU -> ifid_flush=1.
REQ-034 Halt: id_halt=1 in RUN -> 3 DRAIN cycles with ifid_flush=1, then halted=1 persists; a subsequent id_jump=1 causes no flush; rst_n pulse -> halted=0.
REQ-035 Saturation: 70000 consecutive LU cycles -> stall_cnt=16'hFFFF.
REQ-036 With PIPE_STEP_EN, step held high for 5 cycles -> exactly 1 cycle with pipe_freeze=0, then pipe_freeze=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard, forwarding and halt controller for a classic 5-stage pipeline.
//   - Detects load-use hazards in ID. On a hazard it stalls PC and IF/ID and
//     injects a bubble into ID/EX for one cycle.
//   - Flushes IF/ID on a taken branch or a jump. A load-use stall takes
//     priority over the flush.
//   - Selects the EX operand source: 10 = EX/MEM, 01 = MEM/WB,
//     00 = register file. EX/MEM has priority over MEM/WB.
//   - Handles a halt with RUN -> DRAIN (3 cycles) -> HALTED. Only reset
//     leaves HALTED.
//   - Keeps a saturating 16-bit count of load-use stall cycles.
//
// Configuration:
//   PIPE_STEP_EN  When defined, the pipeline advances one cycle per rising
//                 edge of step. On every other cycle it is frozen.
//                 When undefined, step is ignored and pipe_freeze is 0.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   id_rs, id_rt, id_uses_rt       ID source registers / rt-read flag
//   id_branch_taken, id_jump,
//   id_halt                        ID control-flow events
//   ex_memread, ex_rt, ex_rs       EX load flag and source registers
//   mem_regwrite, mem_rd           EX/MEM writeback intent / destination
//   wb_regwrite, wb_rd             MEM/WB writeback intent / destination
//   step                           single-step request (level, sync)
//   pc_write, ifid_write           PC / IF/ID load enables
//   ifid_flush, idex_flush         IF/ID nop / ID/EX bubble
//   fwd_a, fwd_b                   EX operand source selects
//   pipe_freeze                    hold all pipeline registers and PC
//   halted                         pipeline has finished draining
//   stall_cnt                      saturating load-use stall counter
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_branch_taken,
  input  logic        id_jump,
  input  logic        id_halt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rs,
  input  logic        mem_regwrite,
  input  logic        wb_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        step,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        pipe_freeze,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  state_e      state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic [15:0] stall_q, stall_d;
  logic        halted_q, halted_d;
  logic        lu;
  logic        adv;

  // ------------------------------------------------------------------------
  // Advance qualifier.
  // ------------------------------------------------------------------------
`ifdef PIPE_STEP_EN
  logic step_q;

  // One advance cycle per step rise, however long step is held.
  assign adv = step & ~step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
`else
  logic unused_step;
  assign unused_step = step;
  assign adv         = 1'b1;
`endif

  // Load-use hazard. r0 is never a real dependency.
  assign lu = ex_memread && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // ------------------------------------------------------------------------
  // Forwarding select. The freshest producer (EX/MEM) wins.
  // ------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src))
      return FWD_MEM;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Outputs are qualified with rst_n so they show their reset values for as
  // long as reset is held, whatever the hazard inputs are doing.
  assign fwd_a = rst_n ? fwd_sel(ex_rs) : FWD_RF;
  assign fwd_b = rst_n ? fwd_sel(ex_rt) : FWD_RF;

  // ------------------------------------------------------------------------
  // Control outputs and next state.
  // ------------------------------------------------------------------------
  // NOTE: every signal written here gets a default value first. A path that
  // leaves a signal unassigned would infer a latch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;
    stall_d     = stall_q;
    halted_d    = halted_q;

    if (!rst_n) begin
      // Keep the reset-time defaults.
    end else if (!adv) begin
      // A frozen cycle holds every register, including the FSM and counters.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (lu) begin
            // The stall wins over branch/jump and defers a halt.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
          end else begin
            if (id_branch_taken || id_jump) ifid_flush = 1'b1;
            if (id_halt) begin
              state_d = ST_DRAIN;
              drain_d = 2'd3;
            end
          end
        end

        ST_DRAIN: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          drain_d    = drain_q - 2'd1;
          // Leave after the third drain cycle, when the counter reaches 0.
          if (drain_q <= 2'd1) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end
        end

        ST_HALTED: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end

        default: begin
          state_d = ST_RUN;
          drain_d = 2'd0;
        end
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments, so every register samples the
  // values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      drain_q  <= 2'd0;
      stall_q  <= 16'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      stall_q  <= stall_d;
      halted_q <= halted_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed tests for pipeline_hazard_ctrl. Expected values are worked out
//   by hand. Inputs change 1 ns after the rising edge. Outputs are sampled
//   1 ns after that.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt, ex_rs, mem_rd, wb_rd;
  logic        id_uses_rt, id_branch_taken, id_jump, id_halt, ex_memread;
  logic        mem_regwrite, wb_regwrite, step;
  logic        pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        pipe_freeze, halted;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_branch_taken (id_branch_taken),
    .id_jump         (id_jump),
    .id_halt         (id_halt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_rs           (ex_rs),
    .mem_regwrite    (mem_regwrite),
    .wb_regwrite     (wb_regwrite),
    .mem_rd          (mem_rd),
    .wb_rd           (wb_rd),
    .step            (step),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .pipe_freeze     (pipe_freeze),
    .halted          (halted),
    .stall_cnt       (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 0; id_branch_taken = 0;
    id_jump = 0; id_halt = 0; ex_memread = 0; ex_rt = '0; ex_rs = '0;
    mem_regwrite = 0; wb_regwrite = 0; mem_rd = '0; wb_rd = '0;
  endtask

  // Checks the four enable/flush outputs as one packed word
  // {pc_write, ifid_write, ifid_flush, idex_flush}.
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush},
          {28'd0, exp});
  endtask

  initial begin
    clear_inputs();
    step  = 1'b0;
    rst_n = 1'b0;

    // Reset holds the outputs at their defaults even with a hazard and
    // forwarding matches on the inputs.
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
    ex_rs = 5'd9; mem_rd = 5'd9; mem_regwrite = 1;
    #3;
    check_ctl("rst_ctl", 4'b1100);
    check("rst_fwd_a", fwd_a, 2'b00);
    check("rst_stall", stall_cnt, 16'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_freeze", pipe_freeze, 1'b0);
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

`ifndef PIPE_STEP_EN
    // Load-use on rs: one stall cycle, counter 0 -> 1.
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    check_ctl("lu_ctl", 4'b0001);
    check("lu_cnt_before", stall_cnt, 16'd0);
    tick();
    clear_inputs();
    #1;
    check_ctl("lu_after_ctl", 4'b1100);
    check("lu_cnt_after", stall_cnt, 16'd1);

    // A load into r0 and an rt match without id_uses_rt are not hazards.
    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    check_ctl("lu_r0", 4'b1100);
    ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 0;
    #1;
    check_ctl("lu_rt_unused", 4'b1100);
    clear_inputs();

    // Forwarding priority.
    ex_rs = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9; mem_regwrite = 1; wb_regwrite = 1;
    #1;
    check("fwd_a_mem", fwd_a, 2'b10);
    mem_regwrite = 0;
    #1;
    check("fwd_a_wb", fwd_a, 2'b01);
    mem_rd = 5'd0; wb_rd = 5'd0;
    #1;
    check("fwd_a_rf", fwd_a, 2'b00);
    ex_rt = 5'd3; wb_rd = 5'd3; wb_regwrite = 1;
    #1;
    check("fwd_b_wb", fwd_b, 2'b01);
    clear_inputs();

    // Load-use together with a taken branch: the stall wins.
    ex_memread = 1; ex_rt = 5'd10; id_rt = 5'd10; id_uses_rt = 1;
    id_branch_taken = 1;
    #1;
    check_ctl("lu_br_ctl", 4'b0001);
    tick();
    ex_memread = 0;
    #1;
    check_ctl("br_flush_ctl", 4'b1110);
    check("lu_br_cnt", stall_cnt, 16'd2);
    tick();
    clear_inputs();

    // A halt under a load-use stall is ignored.
    ex_memread = 1; ex_rt = 5'd4; id_rs = 5'd4; id_halt = 1;
    #1;
    check_ctl("halt_lu_ctl", 4'b0001);
    tick();
    clear_inputs();
    tick();
    check_ctl("halt_lu_still_run", 4'b1100);
    check("halt_lu_cnt", stall_cnt, 16'd3);

    // Halt: three DRAIN cycles, then HALTED on the fourth edge.
    id_halt = 1;
    #1;
    check_ctl("halt_seen_ctl", 4'b1100);
    tick();
    id_halt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ctl($sformatf("drain%0d_ctl", i), 4'b0010);
      check($sformatf("drain%0d_halted", i), halted, 1'b0);
      tick();
    end
    check("halted_rise", halted, 1'b1);
    check_ctl("halted_ctl", 4'b0001);
    id_jump = 1; ex_memread = 1; ex_rt = 5'd7; id_rs = 5'd7;
    #1;
    check_ctl("halted_jump_ctl", 4'b0001);
    tick();
    check("halted_persist", halted, 1'b1);
    check("halted_no_cnt", stall_cnt, 16'd3);
    clear_inputs();

    // Reset takes effect asynchronously, between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_halted", halted, 1'b0);
    check("rst_async_cnt", stall_cnt, 16'd0);
    check_ctl("rst_async_ctl", 4'b1100);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of DRAIN returns to RUN.
    id_halt = 1;
    tick();
    id_halt = 0;
    tick();
    #1;
    check_ctl("mid_drain_ctl", 4'b0010);
    rst_n = 1'b0;
    #1;
    check_ctl("mid_drain_rst_ctl", 4'b1100);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_ctl("post_rst_run_ctl", 4'b1100);
    check("post_rst_halted", halted, 1'b0);

    // step is ignored and the pipeline never freezes.
    step = 1;
    #1;
    check("no_step_freeze_hi", pipe_freeze, 1'b0);
    tick();
    step = 0;
    #1;
    check("no_step_freeze_lo", pipe_freeze, 1'b0);

    // Saturation: 70000 consecutive load-use cycles.
    ex_memread = 1; ex_rt = 5'd12; id_rs = 5'd12;
    for (int i = 0; i < 65535; i++) tick();
    check("sat_exact", stall_cnt, 16'hFFFF);
    for (int i = 0; i < 4465; i++) tick();
    check("sat_hold", stall_cnt, 16'hFFFF);
    check_ctl("sat_ctl", 4'b0001);
    clear_inputs();
`else
    // Single step: holding step high for 5 cycles gives one advance cycle.
    begin
      int adv_cycles;
      adv_cycles = 0;
      #1;
      check("step_idle_freeze", pipe_freeze, 1'b1);
      check_ctl("step_idle_ctl", 4'b0000);
      step = 1;
      for (int i = 0; i < 5; i++) begin
        #1;
        if (pipe_freeze == 1'b0) adv_cycles++;
        tick();
      end
      check("step_adv_cycles", adv_cycles, 1);
      #1;
      check("step_freeze_after", pipe_freeze, 1'b1);
      step = 0;
      // A load-use seen only in frozen cycles must not count.
      ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
      tick();
      check("step_frozen_cnt", stall_cnt, 16'd0);
      step = 1;
      #1;
      check_ctl("step_lu_ctl", 4'b0001);
      tick();
      check("step_lu_cnt", stall_cnt, 16'd1);
      clear_inputs();
      step = 0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
